// File: rtl/bram_window_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_window_reader_if
// Purpose  : BRAM read port plus 3x3 window valid/ready channel.
// Revision : 1.0  initial release
// ============================================================================
interface bram_window_reader_if #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                   o_rd_en;
  logic [ADDR_WIDTH-1:0]  o_addr;
  logic [RAM_WIDTH-1:0]   i_rd_data;
  logic [9*RAM_WIDTH-1:0] o_window;
  logic                   o_valid;
  logic                   i_ready;

  // master: the window reader; slave: BRAM plus convolution datapath
  modport master (
    output o_rd_en,
    output o_addr,
    input  i_rd_data,
    output o_window,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_rd_en,
    input  o_addr,
    output i_rd_data,
    input  o_window,
    input  o_valid,
    output i_ready
  );
endinterface
`default_nettype wire

// File: rtl/bram_window_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_window_reader
// Purpose  : Reads a resident frame in column strips and emits 3x3 windows.
// Revision : 1.0  initial release
// ============================================================================
module bram_window_reader #(
  parameter int RAM_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            i_start,
  output logic                 o_busy,
  output logic                 o_done,
  bram_window_reader_if.master bus
);

  localparam int c_col_w = $clog2(IMAGE_WIDTH);
  localparam int c_row_w = $clog2(IMAGE_HEIGHT);

  localparam logic [c_col_w-1:0]    c_col_last = c_col_w'(IMAGE_WIDTH - 3);
  localparam logic [c_row_w-1:0]    c_row_last = c_row_w'(IMAGE_HEIGHT - 1);
  localparam logic [c_row_w-1:0]    c_row_full = c_row_w'(2);
  localparam logic [c_row_w-1:0]    c_row_one  = c_row_w'(1);
  localparam logic [c_col_w-1:0]    c_col_one  = c_col_w'(1);
  localparam logic [ADDR_WIDTH-1:0] c_stride   = ADDR_WIDTH'(IMAGE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LAST  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [c_col_w-1:0]     col_q,   col_d;
  logic [c_row_w-1:0]     row_q,   row_d;
  logic [1:0]             k_q,     k_d;
  logic [ADDR_WIDTH-1:0]  base_q,  base_d;
  logic [2*RAM_WIDTH-1:0] nrow_q,  nrow_d;
  logic [9*RAM_WIDTH-1:0] win_q,   win_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      k_q     <= '0;
      base_q  <= '0;
      nrow_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      k_q     <= k_d;
      base_q  <= base_d;
      nrow_q  <= nrow_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    k_d     = k_q;
    base_d  = base_q;
    nrow_d  = nrow_q;
    win_d   = win_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_FETCH;
          col_d   = '0;
          row_d   = '0;
          k_d     = '0;
          base_d  = '0;
        end
      end

      // Read data lags the request by one cycle, so slot k-1 lands while k is issued.
      S_FETCH: begin
        if (k_q == 2'd1) begin
          nrow_d[0 +: RAM_WIDTH] = bus.i_rd_data;
        end
        if (k_q == 2'd2) begin
          nrow_d[RAM_WIDTH +: RAM_WIDTH] = bus.i_rd_data;
          k_d     = '0;
          state_d = S_LAST;
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      // Row 0 sits in the low bits, so the shift drops the oldest row off the bottom.
      S_LAST: begin
        win_d = {bus.i_rd_data, nrow_q, win_q[9*RAM_WIDTH-1:3*RAM_WIDTH]};
        if (row_q >= c_row_full) begin
          state_d = S_EMIT;
        end else begin
          row_d   = row_q + c_row_one;
          base_d  = base_q + c_stride;
          state_d = S_FETCH;
        end
      end

      S_EMIT: begin
        if (bus.i_ready) begin
          if (row_q != c_row_last) begin
            row_d   = row_q + c_row_one;
            base_d  = base_q + c_stride;
            state_d = S_FETCH;
          end else if (col_q != c_col_last) begin
            col_d   = col_q + c_col_one;
            row_d   = '0;
            base_d  = ADDR_WIDTH'(col_q) + c_addr_one;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_rd_en  = (state_q == S_FETCH);
  assign bus.o_addr   = (state_q == S_FETCH) ? (base_q + ADDR_WIDTH'(k_q)) : '0;
  assign bus.o_window = win_q;
  assign bus.o_valid  = (state_q == S_EMIT);
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);

endmodule
`default_nettype wire
